// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (load-use stall, branch flush,
// data-memory wait with sticky timeout) plus optional performance counters.
// Define HAZARD_PERF_EN to build the stall/flush counters; otherwise the
// counter ports are tied to zero.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_WAIT     = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rt_ex,
    input  logic        MemRead_ex,
    input  logic        branch_taken_ex,
    input  logic        dmem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        pipe_hold,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t     state, state_nx, eff_state;
    logic [1:0] flush_left, flush_left_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       load_use;

    assign load_use = MemRead_ex && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

    // Mealy decode of controls and next state; MEM_WAIT releasing behaves as its target state
    always_comb begin
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        idex_bubble   = 1'b0;
        ifid_flush    = 1'b0;
        pipe_hold     = 1'b0;
        state_nx      = state;
        flush_left_nx = flush_left;
        wait_cnt_nx   = wait_cnt;
        eff_state     = state;
        if (dmem_busy) begin
            pipe_hold   = 1'b1;
            state_nx    = MEM_WAIT;
            wait_cnt_nx = (wait_cnt >= WAIT_LIM) ? WAIT_LIM : wait_cnt + 8'd1;
        end else begin
            wait_cnt_nx = '0;
            if (state == MEM_WAIT)
                eff_state = (flush_left != '0) ? FLUSH : RUN;
            if (eff_state == FLUSH) begin
                pc_write      = 1'b1;
                ifid_write    = 1'b1;
                ifid_flush    = 1'b1;
                idex_bubble   = 1'b1;
                flush_left_nx = flush_left - 2'd1;
                state_nx      = (flush_left == 2'd1) ? RUN : FLUSH;
            end else if (branch_taken_ex) begin
                pc_write      = 1'b1;
                ifid_write    = 1'b1;
                ifid_flush    = 1'b1;
                idex_bubble   = 1'b1;
                flush_left_nx = FL_INIT;
                state_nx      = (FL_INIT != '0) ? FLUSH : RUN;
            end else if (load_use) begin
                idex_bubble   = 1'b1;
                state_nx      = RUN;
            end else begin
                pc_write      = 1'b1;
                ifid_write    = 1'b1;
                state_nx      = RUN;
            end
        end
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b0;
            ifid_flush  = 1'b0;
            pipe_hold   = 1'b0;
        end
    end

    // State, flush/wait bookkeeping and sticky timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            flush_left  <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state      <= state_nx;
            flush_left <= flush_left_nx;
            wait_cnt   <= wait_cnt_nx;
            if (dmem_busy && (wait_cnt_nx == WAIT_LIM))
                mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating performance counters for stalled and flushed cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
            if (ifid_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, range 1..3: number of cycles the front end is squashed after a taken branch.
REQ-002 Parameter MAX_WAIT, default 255, range 1..255: data-memory wait cycles before mem_timeout is flagged.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rs_id, rt_id  in  5 each  source registers of the instruction in ID.
REQ-006 rt_ex  in  5  destination register of the instruction in EX.
REQ-007 MemRead_ex  in  1  the EX instruction is a load.
REQ-008 branch_taken_ex  in  1  a branch or jump resolved taken in EX this cycle.
REQ-009 dmem_busy  in  1  data memory has not completed the MEM-stage access.
REQ-010 pc_write, ifid_write  out  1 each  PC and IF/ID register enables.
REQ-011 idex_bubble  out  1  load zeros (NOP, RegWrite=0, MemRead=0) into ID/EX.
REQ-012 ifid_flush  out  1  clear IF/ID to NOP.
REQ-013 pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB, and suppress the register-file write.
REQ-014 mem_timeout  out  1  sticky; the wait limit was reached.
REQ-015 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-016 The FSM SHALL have three states: RUN, FLUSH, MEM_WAIT; outputs are Mealy, decoded from the state and the current inputs.
REQ-017 Priority: dmem_busy > branch flush > load-use stall.
REQ-018 Load-use condition: MemRead_ex && rt_ex!=0 && (rt_ex==rs_id || rt_ex==rt_id); in RUN it gives pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle; the state stays RUN.
REQ-019 branch_taken_ex in RUN (dmem_busy=0): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; load-use is ignored; if FLUSH_CYCLES>1, go to FLUSH with flush_left=FLUSH_CYCLES-1.
REQ-020 FLUSH: same outputs as REQ-019; flush_left decrements each cycle; RUN when it reaches 0; load-use and branch_taken_ex are ignored.
REQ-021 dmem_busy=1 in any state: pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0; the state becomes MEM_WAIT; flush_left is preserved.
REQ-022 MEM_WAIT: wait_cnt increments per busy cycle, saturating at MAX_WAIT; wait_cnt==MAX_WAIT sets mem_timeout, which is cleared only by reset; the FSM keeps waiting.
REQ-023 MEM_WAIT with dmem_busy=0: outputs follow the target state this cycle; the target is FLUSH if flush_left>0, else RUN; wait_cnt clears.
REQ-024 With no hazard: pc_write=1, ifid_write=1, and all other controls 0.

Reset
REQ-025 While rst_n=0: state=RUN, flush_left=0, wait_cnt=0, mem_timeout=0, counters=0, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0, pipe_hold=0.
REQ-026 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abandon the operation immediately with no residual flush or stall after release.
REQ-027 First edge after rst_n deasserts: normal RUN decoding.

Configuration
REQ-028 Macro HAZARD_PERF_EN, when defined: stall_cnt counts each cycle with pc_write=0 (rst_n=1); flush_cnt counts each cycle with ifid_flush=1; both saturate at 16'hFFFF.
REQ-029 Macro HAZARD_PERF_EN, when undefined: the counter logic is absent, the ports remain, and both counters are driven constant 0.

Verification
REQ-030 MemRead_ex=1, rt_ex=5, rs_id=5 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle only; next cycle with MemRead_ex=0 -> normal.
REQ-031 MemRead_ex=1, rt_ex=0, rt_id=0 -> no stall; MemRead_ex=1, rt_ex=7, rt_id=7 -> stall.
REQ-032 FLUSH_CYCLES=3, branch_taken_ex pulse plus a simultaneous load-use match -> ifid_flush=idex_bubble=1 for 3 consecutive cycles, no stall, flush_cnt +3.
REQ-033 FLUSH_CYCLES=3, branch then dmem_busy=1 for 4 cycles in the second flush cycle -> pipe_hold=1 for 4 cycles, then 2 remaining flush cycles.
REQ-034 MAX_WAIT=4, dmem_busy held 6 cycles -> mem_timeout rises on the 4th busy cycle, stays 1 after busy drops, and clears only on rst_n=0.
REQ-035 rst_n pulsed low mid-MEM_WAIT (async, off-edge) -> all outputs 0 immediately; after release with idle inputs -> pc_write=1, no flush.
